// File: rtl/scroll_display_mux.sv
// scroll_display_mux: scrolls a writable hex-nibble message across a multiplexed active-low 7-segment display.
// Latency: seg_L/anode_L are registered one cycle after dig/ptr/msg; pos is the pointer register itself.
// No backpressure; the optional `SCROLL_HOLD_AT_WRAP_EN pauses HOLD_STEPS ticks each time ptr lands on 0.
module scroll_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 16,
  parameter int SCROLL_DIV  = 50_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter int HOLD_STEPS  = 4,
  localparam int AW = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  msg_we,
  input  logic [AW-1:0]         msg_addr,
  input  logic [3:0]            msg_data,
  output logic [AW-1:0]         pos,
  output logic [6:0]            seg_L,
  output logic [NUM_DIGITS-1:0] anode_L
);

  localparam int SCW = $clog2(SCROLL_DIV);
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SCW-1:0]        scroll_cnt_q, scroll_cnt_d;
  logic [RCW-1:0]        refresh_cnt_q, refresh_cnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [AW-1:0]         ptr_q, ptr_d, ptr_step;
  logic [3:0]            msg_q [MSG_LEN];
  logic [3:0]            msg_d [MSG_LEN];
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  tick;
  logic                  wr_ok;
  logic [AW:0]           sum;
  logic [AW-1:0]         idx;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Scroll divider: counts only while enabled, one-cycle tick on wrap.
  always_comb begin
    scroll_cnt_d = scroll_cnt_q;
    tick         = 1'b0;
    if (en) begin
      if (scroll_cnt_q == SCW'(SCROLL_DIV - 1)) begin
        scroll_cnt_d = '0;
        tick         = 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + SCW'(1);
      end
    end
  end

  // Candidate pointer one step in the sampled direction, wrapping modulo MSG_LEN.
  always_comb begin
    if (dir) begin
      ptr_step = (ptr_q == '0) ? AW'(MSG_LEN - 1) : ptr_q - AW'(1);
    end else begin
      ptr_step = (ptr_q == AW'(MSG_LEN - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

`ifdef SCROLL_HOLD_AT_WRAP_EN
  localparam int HW = (HOLD_STEPS < 1) ? 1 : $clog2(HOLD_STEPS + 1);
  logic [HW-1:0] hold_q, hold_d;

  // Pointer advance; landing on 0 arms a hold that swallows the following ticks.
  always_comb begin
    ptr_d  = ptr_q;
    hold_d = hold_q;
    if (tick) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else begin
        ptr_d = ptr_step;
        if (ptr_step == '0) begin
          hold_d = HW'(HOLD_STEPS);
        end
      end
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_STEPS;

  // Pointer advance on every tick.
  always_comb begin
    ptr_d = tick ? ptr_step : ptr_q;
  end
`endif

  // Refresh divider free-runs; each wrap moves to the next digit.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + RCW'(1);
    dig_d         = dig_q;
    if (refresh_cnt_q == RCW'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      dig_d         = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end
  end

  // Message write port; out-of-range addresses are dropped.
  always_comb begin
    wr_ok = msg_we && ({1'b0, msg_addr} < (AW+1)'(MSG_LEN));
    msg_d = msg_q;
    if (wr_ok) begin
      msg_d[msg_addr] = msg_data;
    end
  end

  // Output pattern for the lit digit: entry (ptr+dig) mod MSG_LEN, digit 0 on the top anode.
  always_comb begin
    sum = {1'b0, ptr_q} + (AW+1)'(dig_q);
    if (sum >= (AW+1)'(MSG_LEN)) begin
      idx = AW'(sum - (AW+1)'(MSG_LEN));
    end else begin
      idx = sum[AW-1:0];
    end
    seg_d = hex_to_seg(msg_q[idx]);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      anode_d[NUM_DIGITS-1-d] = (dig_q != DW'(d));
    end
  end

  // State and output registers; reset restores the identity message.
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_cnt_q  <= '0;
      refresh_cnt_q <= '0;
      dig_q         <= '0;
      ptr_q         <= '0;
      seg_q         <= 7'h7F;
      anode_q       <= '1;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= 4'(i % 16);
      end
    end else begin
      scroll_cnt_q  <= scroll_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      dig_q         <= dig_d;
      ptr_q         <= ptr_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
      msg_q         <= msg_d;
    end
  end

  assign pos     = ptr_q;
  assign seg_L   = seg_q;
  assign anode_L = anode_q;

endmodule

// File: tb/tb_scroll_display_mux.sv
// Bench for scroll_display_mux: a cycle model feeds a scoreboard queue, plus directed scenario checks.
// A second instance with MSG_LEN=10 covers out-of-range writes and non-power-of-two wrap.
// Build with +define+SCROLL_HOLD_AT_WRAP_EN to exercise the wrap hold.
module tb_scroll_display_mux;

  localparam int ND = 4;
  localparam int ML = 16;
  localparam int SD = 8;
  localparam int RD = 4;
  localparam int HS = 2;

  logic       clk = 1'b0;
  logic       rst, en, dir;
  logic       msg_we, we10;
  logic [3:0] msg_addr, msg_data, addr10, data10;
  logic [3:0] pos, pos10;
  logic [6:0] seg_L, seg10;
  logic [3:0] anode_L, an10;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scroll_display_mux #(.NUM_DIGITS(ND), .MSG_LEN(ML), .SCROLL_DIV(SD), .REFRESH_DIV(RD), .HOLD_STEPS(HS)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .msg_we(msg_we), .msg_addr(msg_addr),
    .msg_data(msg_data), .pos(pos), .seg_L(seg_L), .anode_L(anode_L));

  scroll_display_mux #(.NUM_DIGITS(ND), .MSG_LEN(10), .SCROLL_DIV(SD), .REFRESH_DIV(RD), .HOLD_STEPS(HS)) dut10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .msg_we(we10), .msg_addr(addr10),
    .msg_data(data10), .pos(pos10), .seg_L(seg10), .anode_L(an10));

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] pos;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] m_msg [ML];
  int m_ptr, m_scnt, m_rcnt, m_dig, m_hold;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Advance the reference model by one edge using the inputs now on the pins; queue what the pins show after it.
  task automatic model_edge();
    exp_t e;
    if (rst) begin
      m_ptr = 0; m_scnt = 0; m_rcnt = 0; m_dig = 0; m_hold = 0;
      for (int i = 0; i < ML; i++) m_msg[i] = 4'(i);
      e.seg = 7'h7F;
      e.an  = 4'hF;
    end else begin
      e.seg = hex7(m_msg[(m_ptr + m_dig) % ML]);
      e.an  = ~(4'b0001 << (ND - 1 - m_dig));
      if (en) begin
        if (m_scnt == SD - 1) begin
          m_scnt = 0;
`ifdef SCROLL_HOLD_AT_WRAP_EN
          if (m_hold > 0) begin
            m_hold = m_hold - 1;
          end else begin
            m_ptr = dir ? (m_ptr + ML - 1) % ML : (m_ptr + 1) % ML;
            if (m_ptr == 0) m_hold = HS;
          end
`else
          m_ptr = dir ? (m_ptr + ML - 1) % ML : (m_ptr + 1) % ML;
`endif
        end else begin
          m_scnt = m_scnt + 1;
        end
      end
      if (m_rcnt == RD - 1) begin
        m_rcnt = 0;
        m_dig  = (m_dig + 1) % ND;
      end else begin
        m_rcnt = m_rcnt + 1;
      end
      if (msg_we && int'(msg_addr) < ML) m_msg[msg_addr] = msg_data;
    end
    e.pos = 4'(m_ptr);
    sb_q.push_back(e);
  endtask

  // One clock: push the model's prediction, let the edge happen, pop and compare the main instance.
  task automatic cyc();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_vec++;
    if (seg_L !== e.seg) begin
      n_bad++;
      $display("FAIL sb_seg t=%0t got %b want %b", $time, seg_L, e.seg);
    end
    n_vec++;
    if (anode_L !== e.an) begin
      n_bad++;
      $display("FAIL sb_anode t=%0t got %b want %b", $time, anode_L, e.an);
    end
    n_vec++;
    if (pos !== e.pos) begin
      n_bad++;
      $display("FAIL sb_pos t=%0t got %0d want %0d", $time, pos, e.pos);
    end
  endtask

  // Step until the given anode pattern is lit, bounded.
  task automatic wait_anode(input logic [3:0] pat);
    int k;
    k = 0;
    while (anode_L !== pat && k < 40) begin
      cyc();
      k++;
    end
    if (anode_L !== pat) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_anode timeout got %b want %b", anode_L, pat);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b0;
    msg_we = 1'b0; msg_addr = '0; msg_data = '0;
    we10 = 1'b0; addr10 = '0; data10 = '0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (seg_L !== 7'h7F) begin n_bad++; $display("FAIL rst_seg got %b want 1111111", seg_L); end
    n_vec++;
    if (anode_L !== 4'b1111) begin n_bad++; $display("FAIL rst_anode got %b want 1111", anode_L); end
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL rst_pos got %0d want 0", pos); end
    n_vec++;
    if (an10 !== 4'b1111) begin n_bad++; $display("FAIL rst_anode10 got %b want 1111", an10); end
    cyc();
    n_vec++;
    if (anode_L !== 4'b0111) begin n_bad++; $display("FAIL first_anode got %b want 0111", anode_L); end
    n_vec++;
    if (seg_L !== 7'b1000000) begin n_bad++; $display("FAIL first_seg got %b want 1000000", seg_L); end
  endtask

  task automatic test_refresh();
    logic [6:0] first4 [4];
    logic [3:0] an_exp;
    first4 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      cyc();
      an_exp = 4'b1000 >> ((k / 4) % 4);
      an_exp = ~an_exp;
      n_vec++;
      if (anode_L !== an_exp) begin n_bad++; $display("FAIL refresh_anode k=%0d got %b want %b", k, anode_L, an_exp); end
      n_vec++;
      if (seg_L !== first4[(k / 4) % 4]) begin
        n_bad++; $display("FAIL refresh_seg k=%0d got %b want %b", k, seg_L, first4[(k / 4) % 4]);
      end
      n_vec++;
      if (pos !== 4'd0) begin n_bad++; $display("FAIL refresh_pos k=%0d got %0d want 0", k, pos); end
    end
  endtask

  task automatic test_scroll();
    apply_reset();
    en = 1'b1; dir = 1'b0;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd1) begin n_bad++; $display("FAIL scroll_inc_pos got %0d want 1", pos); end
    en = 1'b0;
    wait_anode(4'b0111);
    n_vec++;
    if (seg_L !== 7'b1111001) begin n_bad++; $display("FAIL scroll_inc_left got %b want 1111001", seg_L); end

    apply_reset();
    en = 1'b1; dir = 1'b1;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd15) begin n_bad++; $display("FAIL scroll_dec_pos got %0d want 15", pos); end
    n_vec++;
    if (pos10 !== 4'd9) begin n_bad++; $display("FAIL scroll_dec_pos10 got %0d want 9", pos10); end
    en = 1'b0;
    wait_anode(4'b0111);
    n_vec++;
    if (seg_L !== 7'b0001110) begin n_bad++; $display("FAIL scroll_dec_left got %b want 0001110", seg_L); end
    n_vec++;
    if (seg10 !== 7'b0010000) begin n_bad++; $display("FAIL scroll_dec_left10 got %b want 0010000", seg10); end
    wait_anode(4'b1011);
    n_vec++;
    if (seg10 !== 7'b1000000) begin n_bad++; $display("FAIL scroll_wrap_dig1_10 got %b want 1000000", seg10); end

    en = 1'b1; dir = 1'b0;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL scroll_wrap_pos got %0d want 0", pos); end
    n_vec++;
    if (pos10 !== 4'd0) begin n_bad++; $display("FAIL scroll_wrap_pos10 got %0d want 0", pos10); end
  endtask

  task automatic test_freeze();
    apply_reset();
    en = 1'b1; dir = 1'b0;
    repeat (5) cyc();
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_vec++;
      if (pos !== 4'd0) begin n_bad++; $display("FAIL freeze_pos k=%0d got %0d want 0", k, pos); end
    end
    en = 1'b1;
    repeat (2) cyc();
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL freeze_early got %0d want 0", pos); end
    cyc();
    n_vec++;
    if (pos !== 4'd1) begin n_bad++; $display("FAIL freeze_resume got %0d want 1", pos); end
  endtask

  task automatic test_write();
    logic [3:0] pat;
    apply_reset();
    msg_we = 1'b1; msg_addr = 4'd0; msg_data = 4'd8;
    we10 = 1'b1; addr10 = 4'd12; data10 = 4'd8;
    cyc();
    msg_we = 1'b0; we10 = 1'b0;
    n_vec++;
    if (seg_L !== 7'b1000000) begin n_bad++; $display("FAIL write_same_cycle got %b want 1000000", seg_L); end
    wait_anode(4'b1011);
    wait_anode(4'b0111);
    n_vec++;
    if (seg_L !== 7'b0000000) begin n_bad++; $display("FAIL write_left got %b want 0000000", seg_L); end
    for (int d = 0; d < 4; d++) begin
      pat = 4'b1000 >> d;
      pat = ~pat;
      wait_anode(pat);
      n_vec++;
      if (seg10 !== hex7(4'(d))) begin
        n_bad++; $display("FAIL write_oob10 d=%0d got %b want %b", d, seg10, hex7(4'(d)));
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    en = 1'b1; dir = 1'b1;
    repeat (8) cyc();
    dir = 1'b0;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL hold_land got %0d want 0", pos); end
    repeat (8) cyc();
`ifdef SCROLL_HOLD_AT_WRAP_EN
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL hold_tick1 got %0d want 0", pos); end
    dir = 1'b1;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd0) begin n_bad++; $display("FAIL hold_tick2 got %0d want 0", pos); end
    dir = 1'b0;
    repeat (8) cyc();
    n_vec++;
    if (pos !== 4'd1) begin n_bad++; $display("FAIL hold_resume got %0d want 1", pos); end
`else
    n_vec++;
    if (pos !== 4'd1) begin n_bad++; $display("FAIL nohold_step got %0d want 1", pos); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_refresh();
    test_scroll();
    test_freeze();
    test_write();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
